// File: rtl/dm_lsu_if.sv
// Bus bundles around the load/store unit.
// Latency: none, wires only. Backpressure: req_ready is the only stall signal.
// dm_lsu_if: CPU <-> LSU. master = CPU (req_*), slave = LSU (req_ready, resp_*).
// dm_mem_if: LSU <-> data memory. master = LSU (address, write data, enables), slave = memory (read data).

interface dm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface dm_mem_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic        dm_MemWrite;
  logic        dm_MemRead;
  logic [31:0] dm_read_data;

  modport master (
    output dm_addr, dm_write_data, dm_MemWrite, dm_MemRead,
    input  dm_read_data
  );

  modport slave (
    input  dm_addr, dm_write_data, dm_MemWrite, dm_MemRead,
    output dm_read_data
  );
endinterface

// File: rtl/dm_lsu.sv
// Load/store unit: one byte/half/word request at a time, turned into word-aligned memory accesses.
// Latency (accept cycle = 0): resp in cycle 1 (error), 2 (load, word store), 3 (sub-word store via read-modify-write).
// Backpressure: req_ready is high only in IDLE; req_* are ignored while busy.
// Ports: clk, rst_n (sync, active low); cpu = dm_lsu_if.slave (request/response);
//        mem = dm_mem_if.master (word address, write data, read/write enables, combinational read data).

module dm_lsu #(
  parameter int DM_SIZE = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  dm_lsu_if.slave  cpu,
  dm_mem_if.master mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [31:0] DM_WORDS = 32'(DM_SIZE);

  state_t      state, state_nx;

  // Latched request. The store/load direction is carried by the state path,
  // and only the low 16 bits of store data are needed after acceptance
  // (word stores go straight into the merge register).
  logic [1:0]  size_q, size_nx;
  logic        signed_q, signed_nx;
  logic [31:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [31:0] merge_q, merge_nx;
  logic [31:0] rdata_q, rdata_nx;
  logic        err_q, err_nx;

  // Registered response outputs; zero outside DONE.
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merge_byte;
  logic [31:0] merge_half;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;

  // Request classification. It is evaluated on the incoming request in the
  // same cycle it is latched, so it is identical to judging the latched copy.
  always_comb begin
    req_err = 1'b0;
    case (cpu.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = cpu.req_addr[0];
      2'b10:   req_err = |cpu.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, cpu.req_addr[31:2]} >= DM_WORDS) begin
      req_err = 1'b1;
    end
  end

  // Little-endian lane extraction and sign/zero extension for loads.
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    ld_byte = mem.dm_read_data[7:0];
      2'd1:    ld_byte = mem.dm_read_data[15:8];
      2'd2:    ld_byte = mem.dm_read_data[23:16];
      default: ld_byte = mem.dm_read_data[31:24];
    endcase
    ld_half = addr_q[1] ? mem.dm_read_data[31:16] : mem.dm_read_data[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem.dm_read_data;
    endcase
  end

  // Merge the stored lane into the word just read from memory.
  always_comb begin
    merge_byte = mem.dm_read_data;
    case (addr_q[1:0])
      2'd0:    merge_byte = {mem.dm_read_data[31:8], wdata_q[7:0]};
      2'd1:    merge_byte = {mem.dm_read_data[31:16], wdata_q[7:0], mem.dm_read_data[7:0]};
      2'd2:    merge_byte = {mem.dm_read_data[31:24], wdata_q[7:0], mem.dm_read_data[15:0]};
      default: merge_byte = {wdata_q[7:0], mem.dm_read_data[23:0]};
    endcase
    merge_half = addr_q[1] ? {wdata_q, mem.dm_read_data[15:0]}
                           : {mem.dm_read_data[31:16], wdata_q};
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_nx   = state;
    size_nx    = size_q;
    signed_nx  = signed_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    merge_nx   = merge_q;
    rdata_nx   = rdata_q;
    err_nx     = err_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = 32'h0;

    case (state)
      IDLE: begin
        if (cpu.req_valid) begin
          size_nx   = cpu.req_size;
          signed_nx = cpu.req_signed;
          addr_nx   = cpu.req_addr;
          wdata_nx  = cpu.req_wdata[15:0];
          rdata_nx  = 32'h0;
          err_nx    = req_err;
          if (req_err) begin
            state_nx = DONE;
          end else if (!cpu.req_we) begin
            state_nx = LOAD;
          end else if (cpu.req_size == 2'b10) begin
            merge_nx = cpu.req_wdata;
            state_nx = WRITE;
          end else begin
            state_nx = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        rdata_nx = ld_ext;
        state_nx = DONE;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        // Only byte (00) and halfword (01) stores reach this state.
        merge_nx = size_q[0] ? merge_half : merge_byte;
        state_nx = WRITE;
      end
      WRITE: begin
        mem_write  = 1'b1;
        write_data = merge_q;
        state_nx   = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 16'h0;
      merge_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      size_q       <= size_nx;
      signed_q     <= signed_nx;
      addr_q       <= addr_nx;
      wdata_q      <= wdata_nx;
      merge_q      <= merge_nx;
      rdata_q      <= rdata_nx;
      err_q        <= err_nx;
      // Load the response registers on the way into DONE so they are
      // valid exactly for the DONE cycle and zero otherwise.
      resp_valid_q <= (state_nx == DONE);
      resp_rdata_q <= (state_nx == DONE) ? rdata_nx : 32'h0;
      resp_err_q   <= (state_nx == DONE) & err_nx;
    end
  end

  assign cpu.req_ready  = (state == IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign cpu.resp_err   = resp_err_q;

  assign mem.dm_addr       = {addr_q[31:2], 2'b00};
  assign mem.dm_MemRead    = mem_read;
  // A reset landing on a WRITE cycle must not corrupt memory.
  assign mem.dm_MemWrite   = mem_write & rst_n;
  assign mem.dm_write_data = write_data;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a 64-word behavioural data memory.
// Latency and acceptance timing are checked in cycles relative to acceptance.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_dm_lsu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_lsu_if cpu_if ();
  dm_mem_if mem_if ();

  dm_lsu #(.DM_SIZE(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_if),
    .mem   (mem_if)
  );

  // Data memory: combinational read, write on posedge. Backdoor port for preloading.
  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_dat;

  assign mem_if.dm_read_data = mem[mem_if.dm_addr[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_dat;
    else if (mem_if.dm_MemWrite) mem[mem_if.dm_addr[7:2]] <= mem_if.dm_write_data;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_chk;
  int n_fail;

  task automatic poke(input int idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = 6'(idx); bd_dat = d;
    @(posedge clk); @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drives one request starting at a falling edge in IDLE and returns what was observed.
  // Leaves the bench at the falling edge of the cycle following DONE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic rdy0, output int lat, output logic [31:0] rd,
                        output logic er, output logic acc_seen, output int acc_at);
    rdy0 = cpu_if.req_ready;
    cpu_if.req_valid = 1'b1; cpu_if.req_we = we; cpu_if.req_size = sz;
    cpu_if.req_signed = sg; cpu_if.req_addr = a; cpu_if.req_wdata = wd;
    acc_seen = 1'b0; lat = -1; rd = 32'hxxxxxxxx; er = 1'bx;
    @(posedge clk); @(negedge clk);
    cpu_if.req_valid = 1'b0;
    acc_at = cyc_cnt;
    for (int c = 1; c <= 8; c++) begin
      if (mem_if.dm_MemRead || mem_if.dm_MemWrite) acc_seen = 1'b1;
      if (cpu_if.resp_valid) begin
        lat = c; rd = cpu_if.resp_rdata; er = cpu_if.resp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bd_we = 1'b0; bd_idx = 6'd0; bd_dat = 32'h0;
    cpu_if.req_valid = 1'b0; cpu_if.req_we = 1'b0; cpu_if.req_size = 2'b00;
    cpu_if.req_signed = 1'b0; cpu_if.req_addr = 32'h0; cpu_if.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (cpu_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cpu_if.req_ready); end
    n_chk++; if (cpu_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", cpu_if.resp_valid); end
    n_chk++; if (cpu_if.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", cpu_if.resp_rdata); end
    n_chk++; if (cpu_if.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", cpu_if.resp_err); end
    n_chk++; if (mem_if.dm_MemRead !== 1'b0) begin n_fail++; $display("FAIL rst_memread: got %b expected 0", mem_if.dm_MemRead); end
    n_chk++; if (mem_if.dm_MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite: got %b expected 0", mem_if.dm_MemWrite); end
    n_chk++; if (mem_if.dm_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", mem_if.dm_addr); end
    n_chk++; if (mem_if.dm_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", mem_if.dm_write_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_write();
    logic seen;
    poke(4, 32'h01020304);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b1; cpu_if.req_size = 2'b10;
    cpu_if.req_signed = 1'b0; cpu_if.req_addr = 32'h10; cpu_if.req_wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    cpu_if.req_valid = 1'b0;
    n_chk++; if (mem_if.dm_MemWrite !== 1'b1) begin n_fail++; $display("FAIL rw_write_active: got %b expected 1", mem_if.dm_MemWrite); end
    n_chk++; if (mem_if.dm_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_write_data: got %h expected deadbeef", mem_if.dm_write_data); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (mem_if.dm_MemWrite !== 1'b0) begin n_fail++; $display("FAIL rw_write_gated: got %b expected 0", mem_if.dm_MemWrite); end
    @(posedge clk); @(negedge clk);
    n_chk++; if (mem[4] !== 32'h01020304) begin n_fail++; $display("FAIL rw_mem_kept: got %h expected 01020304", mem[4]); end
    n_chk++; if (cpu_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b expected 1", cpu_if.req_ready); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_if.resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rw_no_resp: got %b expected 0", seen); end
  endtask

  task automatic test_word();
    logic rdy; int lat; logic [31:0] rd; logic er; logic acc; int at;
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, rdy, lat, rd, er, acc, at);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h expected 0", rd); end
    n_chk++; if (mem[2] !== 32'h11223344) begin n_fail++; $display("FAIL sw_mem: got %h expected 11223344", mem[2]); end
    n_chk++; if (cpu_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_pulse: got %b expected 0", cpu_if.resp_valid); end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rdy, lat, rd, er, acc, at);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_chk++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL lw_rdata: got %h expected 11223344", rd); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b expected 0", er); end
    n_chk++; if (mem_if.dm_addr !== 32'h08) begin n_fail++; $display("FAIL lw_addr_held: got %h expected 00000008", mem_if.dm_addr); end
  endtask

  task automatic test_subword();
    logic rdy; int lat; logic [31:0] rd; logic er; logic acc; int at;
    poke(2, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h123456AB, rdy, lat, rd, er, acc, at);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    n_chk++; if (mem[2] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[2]); end
    do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'hCAFEBEEF, rdy, lat, rd, er, acc, at);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d expected 3", lat); end
    n_chk++; if (mem[2] !== 32'hBEEFAB44) begin n_fail++; $display("FAIL sh_mem: got %h expected beefab44", mem[2]); end
    n_chk++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sh_resp: got rdata %h err %b expected 0/0", rd, er); end
  endtask

  task automatic test_load_ext();
    logic rdy; int lat; logic [31:0] rd; logic er; logic acc; int at;
    logic [31:0] va [8];
    logic [1:0]  vs [8];
    logic        vg [8];
    logic [31:0] ve [8];
    va = '{32'h09, 32'h0A, 32'h0B, 32'h0A, 32'h0A, 32'h0B, 32'h08, 32'h08};
    vs = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10};
    vg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ve = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
           32'h000080FF, 32'hFFFFFF80, 32'h00007F01, 32'h80FF7F01};
    poke(2, 32'h80FF7F01);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, vs[i], vg[i], va[i], 32'hFFFFFFFF, rdy, lat, rd, er, acc, at);
      n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL ld%0d_latency: got %0d expected 2", i, lat); end
      n_chk++; if (rd !== ve[i]) begin n_fail++; $display("FAIL ld%0d_rdata: got %h expected %h", i, rd, ve[i]); end
      n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld%0d_err: got %b expected 0", i, er); end
    end
  endtask

  task automatic test_errors();
    logic rdy; int lat; logic [31:0] rd; logic er; logic acc; int at;
    logic        ew [7];
    logic [1:0]  es [7];
    logic [31:0] ea [7];
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
    ea = '{32'h05, 32'h06, 32'h08, 32'h100, 32'h0E, 32'h100, 32'h0D};
    poke(3, 32'h5A5A5A5A);
    for (int i = 0; i < 7; i++) begin
      do_req(ew[i], es[i], 1'b1, ea[i], 32'hFFFFFFFF, rdy, lat, rd, er, acc, at);
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL err%0d_latency: got %0d expected 1", i, lat); end
      n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag: got %b expected 1", i, er); end
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err%0d_rdata: got %h expected 0", i, rd); end
      n_chk++; if (acc !== 1'b0) begin n_fail++; $display("FAIL err%0d_mem_access: got %b expected 0", i, acc); end
    end
    n_chk++; if (mem[3] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL err_mem_kept: got %h expected 5a5a5a5a", mem[3]); end
    // Last word in range is legal.
    poke(63, 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, rdy, lat, rd, er, acc, at);
    n_chk++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL top_word_ok: got latency %0d err %b expected 2/0", lat, er); end
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL top_word_rdata: got %h expected cafef00d", rd); end
  endtask

  task automatic test_busy();
    int lat; logic [31:0] rd; logic ready_seen; logic extra;
    poke(5, 32'h0BADF00D);
    poke(6, 32'h600DCAFE);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b0; cpu_if.req_size = 2'b10;
    cpu_if.req_signed = 1'b0; cpu_if.req_addr = 32'h14; cpu_if.req_wdata = 32'h0;
    @(posedge clk); @(negedge clk);
    lat = -1; rd = 32'h0; ready_seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (cpu_if.req_ready) ready_seen = 1'b1;
      if (cpu_if.resp_valid) begin
        lat = c; rd = cpu_if.resp_rdata;
        cpu_if.req_valid = 1'b0;
        break;
      end
      cpu_if.req_we = 1'b1; cpu_if.req_addr = 32'h18;
      cpu_if.req_wdata = 32'hFFFF0000 | 32'(c);
      @(negedge clk);
    end
    cpu_if.req_valid = 1'b0;
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL busy_latency: got %0d expected 2", lat); end
    n_chk++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL busy_rdata: got %h expected 0badf00d", rd); end
    n_chk++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", ready_seen); end
    extra = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_if.resp_valid) extra = 1'b1;
    end
    n_chk++; if (extra !== 1'b0) begin n_fail++; $display("FAIL busy_extra_resp: got %b expected 0", extra); end
    n_chk++; if (mem[6] !== 32'h600DCAFE) begin n_fail++; $display("FAIL busy_mem_kept: got %h expected 600dcafe", mem[6]); end
  endtask

  task automatic test_back_to_back();
    logic rdy; int lat; logic [31:0] rd; logic er; logic acc;
    int a1, a2, a3, a4;
    poke(8, 32'h13579BDF);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rdy, lat, rd, er, acc, a1);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE, rdy, lat, rd, er, acc, a2);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_load: got %b expected 1", rdy); end
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rdy, lat, rd, er, acc, a3);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_store: got %b expected 1", rdy); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rdy, lat, rd, er, acc, a4);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_err: got %b expected 1", rdy); end
    n_chk++; if (a2 - a1 !== 3) begin n_fail++; $display("FAIL b2b_load_gap: got %0d expected 3", a2 - a1); end
    n_chk++; if (a3 - a2 !== 4) begin n_fail++; $display("FAIL b2b_rmw_gap: got %0d expected 4", a3 - a2); end
    n_chk++; if (a4 - a3 !== 2) begin n_fail++; $display("FAIL b2b_err_gap: got %0d expected 2", a4 - a3); end
    n_chk++; if (rd !== 32'h1357EEDF) begin n_fail++; $display("FAIL b2b_rdata: got %h expected 1357eedf", rd); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_reset_in_write();
    test_word();
    test_subword();
    test_load_ext();
    test_errors();
    test_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
